wbs_mem_ctrl: RTL and testbench
===============================

Name: wbs_mem_ctrl

Overview:
Wishbone classic slave controller for the KD-tree ANN accelerator. It decodes host accesses into control/status registers and four memory regions: query, leaf, best, node. It packs 32-bit bus beats into 64-bit memory words and sequences a single shared SRAM port. It also arbitrates that port against the search FSM: host memory access is locked out while the FSM is busy.

Parameters:
ADDR_MASK, 32'hFFFF_0000, region-select mask
REG_BASE, 32'h3000_0000, control register block (offsets 0x0 mode, 0x4 debug, 0x8 done, 0xC fsm_start, 0x10 fsm_busy)
QUERY_BASE, 32'h3001_0000, query patch region (64-bit words)
LEAF_BASE, 32'h3002_0000, leaf region (64-bit words)
BEST_BASE, 32'h3003_0000, best-match region (64-bit words, read-only)
NODE_BASE, 32'h3004_0000, internal-node region (32-bit words, 22 bits used)
MEM_ADDR_WIDTH, 12, memory word-address width

Ports:
clk  in  1  system clock (wb_clk_i at top)
rst_n  in  1  asynchronous active-low reset
wbs_cyc_i  in  1  bus cycle
wbs_stb_i  in  1  strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte select (must be 4'hF; others write nothing, ack still given)
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
mem_region  out  2  0 query, 1 leaf, 2 best, 3 node
mem_csb  out  1  SRAM chip select, active low
mem_web  out  1  SRAM write enable, active low
mem_addr  out  MEM_ADDR_WIDTH  word address
mem_wdata  out  64  write data
mem_rdata  in  64  read data, valid 1 cycle after csb low/web high
fsm_busy  in  1  search FSM running
fsm_done  in  1  one-cycle done pulse
fsm_start  out  1  one-cycle start pulse
mode  out  1  mode register bit 0
debug  out  1  debug register bit 0
lockout_err  out  1  sticky: memory access attempted while busy

Behaviour:
- Reset: ack=0, dat_o=0, csb=1, web=1, addr=0, wdata=0, region=0, fsm_start=0, mode=0, debug=0, done=0, lockout_err=0, hold register=0, state IDLE. Asynchronous reset mid-transaction aborts the transaction with no ack; a half-written 64-bit word is discarded.
- States: IDLE, RD_WAIT, ACK. A request is cyc&stb sampled in IDLE.
- Every ACK lasts exactly 1 cycle, then the FSM returns to IDLE. If stb is still high in IDLE, it is a new transaction.
- Register write: IDLE->ACK; ack on the cycle after the request.
  - mode/debug take dat_i[0].
  - A done write clears done.
  - A fsm_start write with dat_i[0]=1 pulses fsm_start for 1 cycle only if fsm_busy=0, and clears done; otherwise ignored.
  - busy writes are ignored.
- Register read: IDLE->ACK; dat_o={31'b0,bit}; busy reflects fsm_busy live. Unmapped offsets read 0.
- Memory addressing for 64-bit regions: word = adr[MEM_ADDR_WIDTH+2:3]; half = adr[2]. Node region: word = adr[MEM_ADDR_WIDTH+1:2].
- 64-bit write, lower half (half=0): latch dat_i into hold[31:0]; no SRAM access; ack after 1 cycle.
- 64-bit write, upper half (half=1): single SRAM write with csb=0, web=0, wdata={dat_i,hold[31:0]}; ack the next cycle. The lower half need not share the same word address (the upper half's word wins).
- Node write: wdata={42'b0,dat_i[21:0]}, single SRAM write.
- Best-region write: acked, dropped, no error.
- Memory read: csb=0, web=1 in IDLE->RD_WAIT. mem_rdata is captured in RD_WAIT, then ACK. dat_o = rdata[31:0] for half=0, rdata[63:32] for half=1; node reads return rdata[31:0]. Ack arrives 2 cycles after the request.
- Arbitration: while fsm_busy=1, memory-region requests are acked after 1 cycle with no SRAM activity, dat_o=0, and lockout_err is set. Register access is always allowed. lockout_err clears on a write to the debug register.
- Port ownership: csb=1 whenever the controller is not issuing, so the FSM owns the SRAM when busy. fsm_busy rising during RD_WAIT does not abort an in-flight read.
- Done tracking: fsm_done sets done. On the same cycle as a done-clear write, set wins.
- wbs_dat_o holds its value until the next read ack; it is 0 after writes.
- cyc dropped mid-RD_WAIT: the read completes internally, no ack is issued, and the FSM returns to IDLE.

Test Plan:
- Reset, then read 0x3000_0010 with fsm_busy=1 -> ack 1 cycle after request, dat_o=1; all outputs at reset values before.
- Write leaf 0x3002_0008=0x1234_5678 then 0x3002_000C=0x0000_00AB -> one SRAM write, region=1, addr=1, wdata=0x0000_00AB_1234_5678; no SRAM activity on the first beat.
- Write node 0x3004_0004=0xFFFF_FFFF -> region=3, addr=1, wdata=0x3F_FFFF.
- mem_rdata=0xDEAD_BEEF_0000_07FF; read 0x3003_0000, then 0x3003_0004 -> dat_o 0x0000_07FF then 0xDEAD_BEEF, each ack 2 cycles after request.
- fsm_busy=1 during a query write -> ack, csb stays 1, lockout_err=1; fsm_start write while busy -> no pulse.
- fsm_start write with busy=0 -> 1-cycle pulse; a later fsm_done pulse makes the done read return 1. Reset asserted during RD_WAIT -> no ack, state IDLE.

Source files
------------

// File: rtl/wbs_mem_ctrl.sv
// Wishbone classic slave for the KD-tree ANN accelerator: control registers plus
// a shared 64-bit SRAM port for query/leaf/best/node regions, locked out while the search FSM runs.
//
// state   | meaning
// IDLE    | waiting for cyc&stb; decodes and launches the access
// RD_WAIT | SRAM read issued, capture mem_rdata
// ACK     | one-cycle acknowledge, back to IDLE
module wbs_mem_ctrl #(
    parameter logic [31:0] ADDR_MASK      = 32'hFFFF_0000,
    parameter logic [31:0] REG_BASE       = 32'h3000_0000,
    parameter logic [31:0] QUERY_BASE     = 32'h3001_0000,
    parameter logic [31:0] LEAF_BASE      = 32'h3002_0000,
    parameter logic [31:0] BEST_BASE      = 32'h3003_0000,
    parameter logic [31:0] NODE_BASE      = 32'h3004_0000,
    parameter int          MEM_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic [1:0]                mem_region,
    output logic                      mem_csb,
    output logic                      mem_web,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [63:0]               mem_wdata,
    input  logic [63:0]               mem_rdata,
    input  logic                      fsm_busy,
    input  logic                      fsm_done,
    output logic                      fsm_start,
    output logic                      mode,
    output logic                      debug,
    output logic                      lockout_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_RD_WAIT, ST_ACK} state_t;

    localparam logic [1:0] RGN_QUERY = 2'd0;
    localparam logic [1:0] RGN_LEAF  = 2'd1;
    localparam logic [1:0] RGN_BEST  = 2'd2;
    localparam logic [1:0] RGN_NODE  = 2'd3;

    state_t                    state_q, state_d;
    logic                      ack_q, ack_d;
    logic [31:0]               dat_q, dat_d;
    logic [1:0]                region_q, region_d;
    logic                      csb_q, csb_d;
    logic                      web_q, web_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [63:0]               wdata_q, wdata_d;
    logic                      start_q, start_d;
    logic                      mode_q, mode_d;
    logic                      debug_q, debug_d;
    logic                      done_q, done_d;
    logic                      lockout_q, lockout_d;
    logic [31:0]               hold_q, hold_d;
    logic                      rd_hi_q, rd_hi_d;

    logic        req, sel_ok, half;
    logic        is_reg, is_query, is_leaf, is_best, is_node, is_mem;
    logic [15:0] reg_off;
    logic [31:0] rgn;
    logic        done_clr, lockout_set, lockout_clr;

    assign req      = wbs_cyc_i & wbs_stb_i;
    assign sel_ok   = (wbs_sel_i == 4'hF);
    assign half     = wbs_adr_i[2];
    assign reg_off  = wbs_adr_i[15:0];
    assign rgn      = wbs_adr_i & ADDR_MASK;
    assign is_reg   = (rgn == REG_BASE);
    assign is_query = (rgn == QUERY_BASE);
    assign is_leaf  = (rgn == LEAF_BASE);
    assign is_best  = (rgn == BEST_BASE);
    assign is_node  = (rgn == NODE_BASE);
    assign is_mem   = is_query | is_leaf | is_best | is_node;

    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        dat_d       = dat_q;
        region_d    = region_q;
        csb_d       = 1'b1;
        web_d       = 1'b1;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        start_d     = 1'b0;
        mode_d      = mode_q;
        debug_d     = debug_q;
        hold_d      = hold_q;
        rd_hi_d     = rd_hi_q;
        done_clr    = 1'b0;
        lockout_set = 1'b0;
        lockout_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    dat_d   = 32'h0;
                    if (is_reg) begin
                        if (wbs_we_i) begin
                            if (sel_ok) begin
                                case (reg_off)
                                    16'h0000: mode_d = wbs_dat_i[0];
                                    16'h0004: begin
                                        debug_d     = wbs_dat_i[0];
                                        lockout_clr = 1'b1;
                                    end
                                    16'h0008: done_clr = 1'b1;
                                    16'h000C: begin
                                        if (wbs_dat_i[0] && !fsm_busy) begin
                                            start_d  = 1'b1;
                                            done_clr = 1'b1;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                        end else begin
                            case (reg_off)
                                16'h0000: dat_d = {31'b0, mode_q};
                                16'h0004: dat_d = {31'b0, debug_q};
                                16'h0008: dat_d = {31'b0, done_q};
                                16'h0010: dat_d = {31'b0, fsm_busy};
                                default:  dat_d = 32'h0;
                            endcase
                        end
                    end else if (is_mem) begin
                        // The search FSM owns the SRAM while busy; host gets a dummy ack.
                        if (fsm_busy) begin
                            lockout_set = 1'b1;
                        end else if (wbs_we_i) begin
                            if (sel_ok) begin
                                if (is_node) begin
                                    csb_d    = 1'b0;
                                    web_d    = 1'b0;
                                    region_d = RGN_NODE;
                                    addr_d   = wbs_adr_i[MEM_ADDR_WIDTH+1:2];
                                    wdata_d  = {{(64-22){1'b0}}, wbs_dat_i[21:0]};
                                end else if (is_best) begin
                                    hold_d = hold_q;
                                end else if (!half) begin
                                    hold_d = wbs_dat_i;
                                end else begin
                                    csb_d    = 1'b0;
                                    web_d    = 1'b0;
                                    region_d = is_leaf ? RGN_LEAF : RGN_QUERY;
                                    addr_d   = wbs_adr_i[MEM_ADDR_WIDTH+2:3];
                                    wdata_d  = {wbs_dat_i, hold_q};
                                end
                            end
                        end else begin
                            state_d = ST_RD_WAIT;
                            ack_d   = 1'b0;
                            dat_d   = dat_q;
                            csb_d   = 1'b0;
                            web_d   = 1'b1;
                            if (is_node) begin
                                region_d = RGN_NODE;
                                addr_d   = wbs_adr_i[MEM_ADDR_WIDTH+1:2];
                                rd_hi_d  = 1'b0;
                            end else begin
                                region_d = is_query ? RGN_QUERY : (is_leaf ? RGN_LEAF : RGN_BEST);
                                addr_d   = wbs_adr_i[MEM_ADDR_WIDTH+2:3];
                                rd_hi_d  = half;
                            end
                        end
                    end
                end
            end
            ST_RD_WAIT: begin
                // An abandoned cycle still lets the SRAM read finish, just without an ack.
                if (wbs_cyc_i) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    dat_d   = rd_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        done_d = done_q;
        if (done_clr) done_d = 1'b0;
        if (fsm_done) done_d = 1'b1;

        lockout_d = lockout_q;
        if (lockout_clr) lockout_d = 1'b0;
        if (lockout_set) lockout_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            dat_q     <= 32'h0;
            region_q  <= 2'd0;
            csb_q     <= 1'b1;
            web_q     <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= 64'h0;
            start_q   <= 1'b0;
            mode_q    <= 1'b0;
            debug_q   <= 1'b0;
            done_q    <= 1'b0;
            lockout_q <= 1'b0;
            hold_q    <= 32'h0;
            rd_hi_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            region_q  <= region_d;
            csb_q     <= csb_d;
            web_q     <= web_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            start_q   <= start_d;
            mode_q    <= mode_d;
            debug_q   <= debug_d;
            done_q    <= done_d;
            lockout_q <= lockout_d;
            hold_q    <= hold_d;
            rd_hi_q   <= rd_hi_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign mem_region  = region_q;
    assign mem_csb     = csb_q;
    assign mem_web     = web_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign fsm_start   = start_q;
    assign mode        = mode_q;
    assign debug       = debug_q;
    assign lockout_err = lockout_q;

endmodule

// File: tb/tb_wbs_mem_ctrl.sv
// Directed bench for wbs_mem_ctrl: register access, beat packing, SRAM reads,
// busy lockout, start/done handshake and reset abort.
module tb_wbs_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [1:0]  mem_region;
    logic        mem_csb, mem_web;
    logic [11:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        fsm_busy, fsm_done, fsm_start;
    logic        mode, debug, lockout_err;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int wr_base;

    wbs_mem_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .mem_region  (mem_region),
        .mem_csb     (mem_csb),
        .mem_web     (mem_web),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .fsm_busy    (fsm_busy),
        .fsm_done    (fsm_done),
        .fsm_start   (fsm_start),
        .mode        (mode),
        .debug       (debug),
        .lockout_err (lockout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && !mem_csb && !mem_web) wr_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
    endtask

    task automatic idle_bus();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    // Single-cycle access (registers, writes, locked-out accesses): ack right after the request edge.
    task automatic acc1(input string tag, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input logic [31:0] exp_dat);
        req(we, adr, dat, sel);
        tick();
        chk({tag, "_ack"}, {63'b0, wbs_ack_o}, 64'd1);
        chk({tag, "_dat"}, {32'b0, wbs_dat_o}, {32'b0, exp_dat});
        idle_bus();
        tick();
        chk({tag, "_ackdrop"}, {63'b0, wbs_ack_o}, 64'd0);
    endtask

    // SRAM read: csb low for one cycle, ack two edges after the request.
    task automatic rd2(input string tag, input logic [31:0] adr, input logic [1:0] exp_rgn,
                       input logic [11:0] exp_addr, input logic [31:0] exp_dat);
        req(1'b0, adr, 32'h0, 4'hF);
        tick();
        chk({tag, "_ack_early"}, {63'b0, wbs_ack_o}, 64'd0);
        chk({tag, "_csb"}, {62'b0, mem_csb, mem_web}, 64'd1);
        chk({tag, "_rgn"}, {62'b0, mem_region}, {62'b0, exp_rgn});
        chk({tag, "_addr"}, {52'b0, mem_addr}, {52'b0, exp_addr});
        tick();
        chk({tag, "_ack"}, {63'b0, wbs_ack_o}, 64'd1);
        chk({tag, "_dat"}, {32'b0, wbs_dat_o}, {32'b0, exp_dat});
        chk({tag, "_csb_rel"}, {63'b0, mem_csb}, 64'd1);
        idle_bus();
        tick();
        chk({tag, "_ackdrop"}, {63'b0, wbs_ack_o}, 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0;
        wbs_dat_i = 32'h0;
        mem_rdata = 64'h0;
        fsm_busy  = 1'b0;
        fsm_done  = 1'b0;
        tick();
        tick();
        chk("rst_ack", {63'b0, wbs_ack_o}, 64'd0);
        chk("rst_dat", {32'b0, wbs_dat_o}, 64'd0);
        chk("rst_csb_web", {62'b0, mem_csb, mem_web}, 64'd3);
        chk("rst_addr", {52'b0, mem_addr}, 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        chk("rst_region", {62'b0, mem_region}, 64'd0);
        chk("rst_ctl", {60'b0, fsm_start, mode, debug, lockout_err}, 64'd0);
        rst_n = 1'b1;
        tick();

        fsm_busy = 1'b1;
        acc1("rd_busy", 1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'h1);
        chk("dat_hold", {32'b0, wbs_dat_o}, 64'd1);
        fsm_busy = 1'b0;

        wr_base = wr_cnt;
        req(1'b1, 32'h3002_0008, 32'h1234_5678, 4'hF);
        tick();
        chk("leaf_lo_ack", {63'b0, wbs_ack_o}, 64'd1);
        chk("leaf_lo_csb", {63'b0, mem_csb}, 64'd1);
        idle_bus();
        tick();
        req(1'b1, 32'h3002_000C, 32'h0000_00AB, 4'hF);
        tick();
        chk("leaf_hi_ack", {63'b0, wbs_ack_o}, 64'd1);
        chk("leaf_hi_csb_web", {62'b0, mem_csb, mem_web}, 64'd0);
        chk("leaf_hi_rgn", {62'b0, mem_region}, 64'd1);
        chk("leaf_hi_addr", {52'b0, mem_addr}, 64'd1);
        chk("leaf_hi_wdata", mem_wdata, 64'h0000_00AB_1234_5678);
        chk("leaf_hi_dat0", {32'b0, wbs_dat_o}, 64'd0);
        idle_bus();
        tick();
        chk("leaf_csb_rel", {63'b0, mem_csb}, 64'd1);
        chk("leaf_wr_count", 64'(wr_cnt - wr_base), 64'd1);

        req(1'b1, 32'h3004_0004, 32'hFFFF_FFFF, 4'hF);
        tick();
        chk("node_csb_web", {62'b0, mem_csb, mem_web}, 64'd0);
        chk("node_rgn", {62'b0, mem_region}, 64'd3);
        chk("node_addr", {52'b0, mem_addr}, 64'd1);
        chk("node_wdata", mem_wdata, 64'h0000_0000_003F_FFFF);
        idle_bus();
        tick();

        wr_base = wr_cnt;
        acc1("best_wr", 1'b1, 32'h3003_0008, 32'h1111_2222, 4'hF, 32'h0);
        chk("best_wr_none", 64'(wr_cnt - wr_base), 64'd0);

        mem_rdata = 64'hDEAD_BEEF_0000_07FF;
        rd2("best_rd_lo", 32'h3003_0000, 2'd2, 12'd0, 32'h0000_07FF);
        rd2("best_rd_hi", 32'h3003_0004, 2'd2, 12'd0, 32'hDEAD_BEEF);
        rd2("node_rd", 32'h3004_0008, 2'd3, 12'd2, 32'h0000_07FF);

        fsm_busy = 1'b1;
        wr_base  = wr_cnt;
        req(1'b1, 32'h3001_000C, 32'h9999_8888, 4'hF);
        tick();
        chk("lock_wr_ack", {63'b0, wbs_ack_o}, 64'd1);
        chk("lock_wr_csb", {63'b0, mem_csb}, 64'd1);
        chk("lock_err", {63'b0, lockout_err}, 64'd1);
        idle_bus();
        tick();
        chk("lock_wr_none", 64'(wr_cnt - wr_base), 64'd0);
        acc1("lock_rd", 1'b0, 32'h3001_0000, 32'h0, 4'hF, 32'h0);
        req(1'b1, 32'h3000_000C, 32'h1, 4'hF);
        tick();
        chk("start_busy", {63'b0, fsm_start}, 64'd0);
        idle_bus();
        tick();
        chk("start_busy2", {63'b0, fsm_start}, 64'd0);
        fsm_busy = 1'b0;
        acc1("dbg_wr", 1'b1, 32'h3000_0004, 32'h1, 4'hF, 32'h0);
        chk("dbg_bit", {62'b0, debug, lockout_err}, 64'd2);

        acc1("mode_wr", 1'b1, 32'h3000_0000, 32'h1, 4'hF, 32'h0);
        acc1("mode_rd", 1'b0, 32'h3000_0000, 32'h0, 4'hF, 32'h1);
        acc1("mode_badsel", 1'b1, 32'h3000_0000, 32'h0, 4'h3, 32'h0);
        chk("mode_kept", {63'b0, mode}, 64'd1);
        acc1("unmapped_rd", 1'b0, 32'h3000_0020, 32'h0, 4'hF, 32'h0);

        req(1'b1, 32'h3000_000C, 32'h1, 4'hF);
        tick();
        chk("start_pulse", {63'b0, fsm_start}, 64'd1);
        idle_bus();
        tick();
        chk("start_pulse_end", {63'b0, fsm_start}, 64'd0);
        acc1("done_rd0", 1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'h0);
        fsm_done = 1'b1;
        tick();
        fsm_done = 1'b0;
        acc1("done_rd1", 1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'h1);
        acc1("done_clr", 1'b1, 32'h3000_0008, 32'h0, 4'hF, 32'h0);
        acc1("done_rd2", 1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'h0);
        req(1'b1, 32'h3000_0008, 32'h0, 4'hF);
        fsm_done = 1'b1;
        tick();
        fsm_done = 1'b0;
        idle_bus();
        tick();
        acc1("done_setwins", 1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'h1);

        req(1'b0, 32'h3002_0000, 32'h0, 4'hF);
        tick();
        chk("cycdrop_csb", {63'b0, mem_csb}, 64'd0);
        idle_bus();
        tick();
        chk("cycdrop_ack", {63'b0, wbs_ack_o}, 64'd0);
        tick();
        chk("cycdrop_ack2", {63'b0, wbs_ack_o}, 64'd0);
        acc1("cycdrop_after", 1'b0, 32'h3000_0000, 32'h0, 4'hF, 32'h1);

        acc1("half_lo", 1'b1, 32'h3002_0010, 32'h5555_AAAA, 4'hF, 32'h0);
        req(1'b0, 32'h3002_0000, 32'h0, 4'hF);
        tick();
        chk("rstrd_csb", {63'b0, mem_csb}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rstrd_ack", {63'b0, wbs_ack_o}, 64'd0);
        chk("rstrd_csb_rel", {63'b0, mem_csb}, 64'd1);
        chk("rstrd_mode", {63'b0, mode}, 64'd0);
        idle_bus();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstrd_noack", {63'b0, wbs_ack_o}, 64'd0);
        req(1'b1, 32'h3002_0014, 32'h0000_0001, 4'hF);
        tick();
        chk("rst_hold_ack", {63'b0, wbs_ack_o}, 64'd1);
        chk("rst_hold_addr", {52'b0, mem_addr}, 64'd2);
        chk("rst_hold_wdata", mem_wdata, 64'h0000_0001_0000_0000);
        idle_bus();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
